// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel switch debouncer: FSM encodings and
// default sizing constants.
package debounce_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT0 = 2'b01,
    ONE   = 2'b10,
    WAIT1 = 2'b11
  } db_state_t;

  localparam int DEF_CNT_W       = 20;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: input synchroniser, 4-state FSM with down-counter and
// level/edge-tick outputs. Optional db_toggle latch when DEBOUNCE_TOGGLE_EN is defined.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db_level,
  output logic db_rise,
`ifdef DEBOUNCE_TOGGLE_EN
  output logic db_fall,
  output logic db_toggle
`else
  output logic db_fall
`endif
);

  localparam logic [CNT_W-1:0] M = '1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  db_state_t              state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   level_nxt;

  assign s = sync[SYNC_STAGES-1];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ZERO:  if (s) begin state_nxt = WAIT1; cnt_nxt = M; end
      WAIT1: begin
        if (!s)            state_nxt = ZERO;
        else if (cnt != '0) cnt_nxt  = cnt - 1'b1;
        else               state_nxt = ONE;
      end
      ONE:   if (!s) begin state_nxt = WAIT0; cnt_nxt = M; end
      WAIT0: begin
        if (s)             state_nxt = ONE;
        else if (cnt != '0) cnt_nxt  = cnt - 1'b1;
        else               state_nxt = ZERO;
      end
      default: state_nxt = ZERO;
    endcase
  end

  // Level tracks the state being entered so it lines up with the state register.
  assign level_nxt = (state_nxt == ONE) || (state_nxt == WAIT0);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync     <= '0;
      state    <= ZERO;
      cnt      <= '0;
      db_level <= 1'b0;
      db_rise  <= 1'b0;
      db_fall  <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], sw};
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      db_level <= level_nxt;
      db_rise  <= level_nxt & ~db_level;
      db_fall  <= ~level_nxt & db_level;
    end
  end

`ifdef DEBOUNCE_TOGGLE_EN
  always_ff @(posedge clk) begin
    if (reset)                       db_toggle <= 1'b0;
    else if (level_nxt & ~db_level)  db_toggle <= ~db_toggle;
  end
`endif

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: CHANNELS independent debounce_chan instances.
// Define DEBOUNCE_TOGGLE_EN to add the per-channel db_toggle output.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] sw,
  output logic [CHANNELS-1:0] db_level,
  output logic [CHANNELS-1:0] db_rise,
`ifdef DEBOUNCE_TOGGLE_EN
  output logic [CHANNELS-1:0] db_fall,
  output logic [CHANNELS-1:0] db_toggle
`else
  output logic [CHANNELS-1:0] db_fall
`endif
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_chan #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .sw       (sw[i]),
      .db_level (db_level[i]),
      .db_rise  (db_rise[i]),
`ifdef DEBOUNCE_TOGGLE_EN
      .db_fall  (db_fall[i]),
      .db_toggle(db_toggle[i])
`else
      .db_fall  (db_fall[i])
`endif
    );
  end

endmodule
